// File: rtl/pwm_decoder_if.sv
// PWM decoder signal bundle: raw PWM input plus decoded results.
// master = PWM source / result consumer, slave = the decoder.
interface pwm_decoder_if #(
  parameter int CNT_W = 28
);
  logic             pwm_in;
  logic [3:0]       duty;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic             stuck;

  modport master (output pwm_in, input duty, high_cnt, period_cnt, valid, stuck);
  modport slave  (input pwm_in, output duty, high_cnt, period_cnt, valid, stuck);
endinterface

// File: rtl/pwm_decoder.sv
// PWM decoder: measures period and high time of pwm_in between rising edges,
// reports duty in sixteenths via a 6-cycle restoring divider, and flags a
// stuck input after TIMEOUT_CYCLES without a rising edge.
// Optional macro PWM_DECODER_GLITCH_FILTER_EN: 4-cycle hold filter on the
// synchronized input (rejects pulses of 3 cycles or less).
module pwm_decoder #(
  parameter int CNT_W          = 28,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input logic         clk,
  input logic         rst,
  pwm_decoder_if.slave bus
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, DIVIDE} state_t;

  state_t           state_q, state_d;
  logic             sync1, sync2, s_in, prev, rise;
  logic [CNT_W-1:0] period_ctr, high_ctr;
  logic [TW-1:0]    to_ctr;
  logic             timeout_hit, latch, finish, fire;
  logic [CNT_W:0]   rem, rem_next;
  logic             q_bit;
  logic [5:0]       quo;
  logic [2:0]       step;
  logic [6:0]       q_half;
  logic [3:0]       duty_calc;
  logic [3:0]       duty_q;
  logic [CNT_W-1:0] high_q, period_q;
  logic             valid_q, stuck_q;

  // Two-flop synchronizer and previous-level register for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.pwm_in;
      sync2 <= sync1;
      prev  <= s_in;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic [2:0] hist;
  logic       filt_q;

  // Level changes only once the current and three previous samples agree
  always_comb begin
    s_in = filt_q;
    if (sync2 && (&hist))
      s_in = 1'b1;
    else if (!sync2 && !(|hist))
      s_in = 1'b0;
  end

  // Filter history and held level
  always_ff @(posedge clk) begin
    if (rst) begin
      hist   <= '0;
      filt_q <= 1'b0;
    end else begin
      hist   <= {hist[1:0], sync2};
      filt_q <= s_in;
    end
  end
`else
  // Unfiltered: decode directly from the synchronizer output
  always_comb s_in = sync2;
`endif

  assign rise        = s_in & ~prev;
  assign timeout_hit = !rise && (to_ctr == TO_PRE);

  // Period/high counters restart on every rising edge and saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      period_ctr <= '0;
      high_ctr   <= '0;
      to_ctr     <= '0;
    end else begin
      if (rise) begin
        period_ctr <= CNT_W'(1);
        high_ctr   <= CNT_W'(1);
        to_ctr     <= '0;
      end else begin
        if (period_ctr != '1) period_ctr <= period_ctr + CNT_W'(1);
        if (s_in && high_ctr != '1) high_ctr <= high_ctr + CNT_W'(1);
        if (to_ctr != TO_MAX) to_ctr <= to_ctr + TW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_EDGE;
    else     state_q <= state_d;
  end

  // Next state and control strobes; timeout overrides everything but a rise
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    finish  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      WAIT_EDGE: if (rise) state_d = MEASURE;
      MEASURE: begin
        if (rise) begin
          latch   = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (step == 3'd6) begin
          finish  = 1'b1;
          state_d = MEASURE;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
    if (timeout_hit) begin
      fire    = 1'b1;
      finish  = 1'b0;
      state_d = WAIT_EDGE;
    end
  end

  // One restoring step: first step compares high_cnt itself (integer bit),
  // later steps work on the doubled remainder (fractional bits)
  always_comb begin
    q_bit    = (rem >= {1'b0, period_q});
    rem_next = q_bit ? (rem - {1'b0, period_q}) : rem;
    q_half   = ({1'b0, quo} + 7'd1) >> 1;
    duty_calc = (q_half > 7'd15) ? 4'd15 : q_half[3:0];
  end

  // Result latching, divider datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      quo      <= '0;
      step     <= '0;
      duty_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (latch) begin
        period_q <= period_ctr;
        high_q   <= high_ctr;
        rem      <= {1'b0, high_ctr};
        quo      <= '0;
        step     <= '0;
      end else if (state_q == DIVIDE && step != 3'd6) begin
        rem  <= rem_next << 1;
        quo  <= {quo[4:0], q_bit};
        step <= step + 3'd1;
      end
      if (finish) begin
        duty_q  <= duty_calc;
        valid_q <= 1'b1;
        stuck_q <= 1'b0;
      end
      if (fire) begin
        duty_q   <= s_in ? 4'd15 : 4'd0;
        high_q   <= '0;
        period_q <= '0;
        valid_q  <= 1'b1;
        stuck_q  <= 1'b1;
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.high_cnt   = high_q;
  assign bus.period_cnt = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck      = stuck_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder (TIMEOUT_CYCLES=200, CNT_W=16).
// Reference model works on the driven waveform: each rising edge closes a
// period; it is reported only if at least 8 cycles passed since the last
// reported edge (decoder still dividing otherwise).
module tb_pwm_decoder;
  localparam int CW = 16;
  localparam int TO = 200;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int FLT = 3;
`else
  localparam int FLT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_decoder_if #(.CNT_W(CW)) bus ();
  pwm_decoder #(.CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int got_d[$], got_h[$], got_p[$];
  int exp_d[$], exp_h[$], exp_p[$];
  int now_t, prev_rise, prev_high, last_latch;
  bit have_prev;

  // Capture every reported result
  always @(negedge clk) begin
    if (bus.valid) begin
      got_d.push_back(int'(bus.duty));
      got_h.push_back(int'(bus.high_cnt));
      got_p.push_back(int'(bus.period_cnt));
    end
  end

  function automatic int model_duty(input int h, input int p);
    int q, d;
    q = (32 * h) / p;
    d = (q + 1) / 2;
    return (d > 15) ? 15 : d;
  endfunction

  task automatic clear_all();
    got_d.delete(); got_h.delete(); got_p.delete();
    exp_d.delete(); exp_h.delete(); exp_p.delete();
    have_prev = 0; last_latch = -1000; now_t = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_all();
  endtask

  task automatic drive(input bit v, input int n);
    bus.pwm_in = v;
    repeat (n) @(negedge clk);
    now_t += n;
  endtask

  task automatic model_rise(input int h);
    if (have_prev && (now_t - last_latch >= 8)) begin
      exp_p.push_back(now_t - prev_rise);
      exp_h.push_back(prev_high);
      exp_d.push_back(model_duty(prev_high, now_t - prev_rise));
      last_latch = now_t;
    end
    have_prev = 1;
    prev_rise = now_t;
    prev_high = h;
  endtask

  task automatic wave(input int h, input int l);
    model_rise(h);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic close_wave();
    model_rise(4);
    drive(1'b1, 4);
    drive(1'b0, 24);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) wave(4 + FLT, 12);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.duty !== 4'd0) begin errors++; $display("FAIL reset_duty got=%0d exp=0", bus.duty); end
    checks++; if (bus.high_cnt !== '0) begin errors++; $display("FAIL reset_high got=%0d exp=0", bus.high_cnt); end
    checks++; if (bus.period_cnt !== '0) begin errors++; $display("FAIL reset_period got=%0d exp=0", bus.period_cnt); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.valid); end
    checks++; if (bus.stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got=%0b exp=0", bus.stuck); end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    repeat (6) wave(4, 12);
    repeat (2) wave(50, 50);
    repeat (2) wave(97, 3);
    repeat (2) wave(2 + FLT, 98 - FLT);
    close_wave();
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL fixed_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL fixed_result[%0d] got d=%0d h=%0d p=%0d exp d=%0d h=%0d p=%0d", i, got_d[i], got_h[i], got_p[i], exp_d[i], exp_h[i], exp_p[i]);
      end
    end
    if (got_d.size() >= 12) begin
      checks++; if (got_d[0] !== 4 || got_h[0] !== 4 || got_p[0] !== 16) begin errors++; $display("FAIL fixed_16_4 got d=%0d h=%0d p=%0d exp d=4 h=4 p=16", got_d[0], got_h[0], got_p[0]); end
      checks++; if (got_d[6] !== 8) begin errors++; $display("FAIL fixed_half got=%0d exp=8", got_d[6]); end
      checks++; if (got_d[8] !== 15) begin errors++; $display("FAIL fixed_sat got=%0d exp=15", got_d[8]); end
      if (FLT == 0) begin
        checks++; if (got_d[10] !== 0) begin errors++; $display("FAIL fixed_low got=%0d exp=0", got_d[10]); end
      end
    end
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    wave(4 + FLT, 30);
    bus.pwm_in = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.valid) break;
    end
    checks++; if (n !== 10 + FLT) begin errors++; $display("FAIL latency got=%0d exp=%0d", n, 10 + FLT); end
    checks++; if (bus.period_cnt !== CW'(34 + FLT) || bus.high_cnt !== CW'(4 + FLT)) begin
      errors++; $display("FAIL latency_vals got h=%0d p=%0d exp h=%0d p=%0d", bus.high_cnt, bus.period_cnt, 4 + FLT, 34 + FLT);
    end
    bus.pwm_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random(input int pmin, input int pmax, input int n, input string name);
    int p, h;
    do_reset();
    for (int k = 0; k < n; k++) begin
      p = $urandom_range(pmax, pmin);
      h = $urandom_range(p - 1 - FLT, 1 + FLT);
      wave(h, p - h);
    end
    close_wave();
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", name, got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL %s[%0d] got d=%0d h=%0d p=%0d exp d=%0d h=%0d p=%0d", name, i, got_d[i], got_h[i], got_p[i], exp_d[i], exp_h[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_short_period();
    do_reset();
    repeat (12) wave(3 + FLT, 3 + FLT);
    close_wave();
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL short_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL short[%0d] got d=%0d h=%0d p=%0d exp d=%0d h=%0d p=%0d", i, got_d[i], got_h[i], got_p[i], exp_d[i], exp_h[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1'b0, 300);
    checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL stuck_low_pulses got=%0d exp=1", got_d.size()); end
    if (got_d.size() > 0) begin
      checks++; if (got_d[0] !== 0 || got_h[0] !== 0 || got_p[0] !== 0) begin errors++; $display("FAIL stuck_low_vals got d=%0d h=%0d p=%0d exp 0 0 0", got_d[0], got_h[0], got_p[0]); end
    end
    checks++; if (bus.stuck !== 1'b1) begin errors++; $display("FAIL stuck_low_flag got=%0b exp=1", bus.stuck); end

    do_reset();
    drive(1'b1, 300);
    checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL stuck_high_pulses got=%0d exp=1", got_d.size()); end
    if (got_d.size() > 0) begin
      checks++; if (got_d[0] !== 15 || got_h[0] !== 0 || got_p[0] !== 0) begin errors++; $display("FAIL stuck_high_vals got d=%0d h=%0d p=%0d exp 15 0 0", got_d[0], got_h[0], got_p[0]); end
    end
    checks++; if (bus.stuck !== 1'b1) begin errors++; $display("FAIL stuck_high_flag got=%0b exp=1", bus.stuck); end

    clear_all();
    drive(1'b0, 4 + FLT);
    repeat (3) wave(4 + FLT, 12);
    close_wave();
    checks++; if (bus.stuck !== 1'b0) begin errors++; $display("FAIL stuck_clear got=%0b exp=0", bus.stuck); end
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL recover_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL recover[%0d] got d=%0d h=%0d p=%0d exp d=%0d h=%0d p=%0d", i, got_d[i], got_h[i], got_p[i], exp_d[i], exp_h[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    wave(2 + FLT, 38 - FLT);
    bus.pwm_in = 1'b1;
    repeat (2 + FLT) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    repeat (15) @(negedge clk);
    checks++; if (got_d.size() !== 0) begin errors++; $display("FAIL abort_pulses got=%0d exp=0", got_d.size()); end
    checks++; if (bus.duty !== 4'd0 || bus.high_cnt !== '0 || bus.period_cnt !== '0 || bus.stuck !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got d=%0d h=%0d p=%0d s=%0b exp all 0", bus.duty, bus.high_cnt, bus.period_cnt, bus.stuck);
    end
    model_rise(4 + FLT);
    drive(1'b1, 4 + FLT);
    drive(1'b0, 36 - FLT);
    checks++; if (got_d.size() !== 0) begin errors++; $display("FAIL abort_first_edge got=%0d exp=0", got_d.size()); end
    close_wave();
    checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL abort_resume_count got=%0d exp=1", got_d.size()); end
    if (got_d.size() > 0 && exp_d.size() > 0) begin
      checks++;
      if (got_d[0] !== exp_d[0] || got_h[0] !== exp_h[0] || got_p[0] !== exp_p[0]) begin
        errors++; $display("FAIL abort_resume got d=%0d h=%0d p=%0d exp d=%0d h=%0d p=%0d", got_d[0], got_h[0], got_p[0], exp_d[0], exp_h[0], exp_p[0]);
      end
    end
  endtask

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  task automatic test_glitch();
    do_reset();
    repeat (6) begin
      model_rise(20);
      drive(1'b1, 8); drive(1'b0, 2); drive(1'b1, 10); drive(1'b0, 20);
    end
    close_wave();
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL glitch_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_d[i] !== 8) begin
        errors++; $display("FAIL glitch[%0d] got=%0d exp=8", i, got_d[i]);
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    clear_all();
    test_reset();
    test_fixed();
    test_latency();
    test_random(8, 150, 30, "random");
    test_random(4 + 2 * FLT, 14 + 2 * FLT, 25, "rand_short");
    test_short_period();
    test_timeout();
    test_reset_mid_divide();
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 28: width of all cycle counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 150_000_000: cycles without a rising edge before declaring a stuck input.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pwm_in, input, 1: asynchronous PWM signal to decode.
REQ-006 SHALL have port duty, output, 4: decoded duty level 0..15 in sixteenths of the period.
REQ-007 SHALL have port high_cnt, output, CNT_W: high-time in clk cycles of the last measured period.
REQ-008 SHALL have port period_cnt, output, CNT_W: rising-to-rising length in clk cycles of the last measured period.
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when duty, high_cnt and period_cnt update.
REQ-010 SHALL have port stuck, output, 1: level flag, input constant for TIMEOUT_CYCLES.

Function
REQ-011 SHALL pass pwm_in through a 2-FF synchronizer; all logic uses the synchronized level s_in and its previous value for edge detect.
REQ-012 SHALL detect a rising edge on the cycle s_in=1 and prev=0, and a falling edge on s_in=0 and prev=1.
REQ-013 SHALL keep a period counter and a high counter; each clears to 1 on a rising edge, otherwise period increments every cycle, high increments while s_in=1; both saturate at 2^CNT_W-1.
REQ-014 SHALL implement FSM states WAIT_EDGE, MEASURE, DIVIDE.
REQ-015 In WAIT_EDGE, the first rising edge SHALL move the FSM to MEASURE without output; this is the state after reset and after a timeout.
REQ-016 In MEASURE, a rising edge SHALL latch the completed period and high counts into period_cnt/high_cnt and enter DIVIDE.
REQ-017 DIVIDE SHALL compute q = floor(32*high_cnt/period_cnt), range 0..32, with a bit-serial restoring divider producing one quotient bit per cycle over 6 cycles.
REQ-018 After DIVIDE, SHALL set duty = min(15, (q+1)>>1), pulse valid for one cycle, clear stuck, and return to MEASURE.
REQ-019 valid SHALL assert exactly 8 cycles after the cycle on which the latching rising edge is detected.
REQ-020 Counters SHALL keep running during DIVIDE; a rising edge detected while in DIVIDE SHALL restart the counters, and that completed period SHALL be dropped, with no output and no FSM disturbance.
REQ-021 A timeout counter SHALL clear on every rising edge; on reaching TIMEOUT_CYCLES in any state, SHALL set stuck=1, duty=15 if s_in=1 else 0, high_cnt=0, period_cnt=0, pulse valid once, and enter WAIT_EDGE.
REQ-022 While stuck=1 and the input is unchanged, SHALL not re-pulse valid; the timeout counter holds at TIMEOUT_CYCLES.
REQ-023 If the timeout and a latching rising edge coincide, the rising edge SHALL win.

Reset
REQ-024 On rst=1 at a clk edge, SHALL set FSM=WAIT_EDGE, duty=0, high_cnt=0, period_cnt=0, valid=0, stuck=0, clear all counters and the synchronizer.
REQ-025 rst asserted mid-DIVIDE SHALL abort the division with no valid pulse.

Configuration
REQ-026 With macro PWM_DECODER_GLITCH_FILTER_EN defined, s_in SHALL change only after the synchronizer output holds a new value for 4 consecutive cycles, suppressing pulses of 3 cycles or less and adding 3 cycles of edge latency.
REQ-027 Without PWM_DECODER_GLITCH_FILTER_EN, s_in SHALL equal the synchronizer output directly, with no filter logic present.

Verification (filter disabled, TIMEOUT_CYCLES=200)
REQ-028 Period 16, high 4, repeated: from the 2nd rising edge on, valid every 16 cycles with period_cnt=16, high_cnt=4, duty=4.
REQ-029 Period 100, high 50: duty=8. High 97: duty=15 after saturation. High 2: duty=0 (q=0).
REQ-030 pwm_in held 0 for 300 cycles after reset: a single valid pulse at the timeout, stuck=1, duty=0. Held 1: duty=15, stuck=1. A later square wave clears stuck on its first valid.
REQ-031 Period 6, below the 8-cycle divide latency: alternate periods are dropped per REQ-020, the FSM never hangs, and every reported value is correct.
REQ-032 rst pulsed 3 cycles into DIVIDE: no valid pulse, all outputs 0, the next result needs two further rising edges.
REQ-033 With PWM_DECODER_GLITCH_FILTER_EN, 2-cycle low glitches inside a 40-cycle, 20-high wave: duty=8 unchanged.
